// File: rtl/elevator_call_conditioner.sv
// Synchronize, debounce and one-shot 7 elevator call buttons; lamps latch until the floor is served.
// Press-to-pulse latency S+DEBOUNCE_CYCLES+1 edges; CALL_SYNC_2FF_EN selects the 2-flop synchronizer (S=2).
module elevator_call_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] btn_raw,
  input  logic       floor_1_indi,
  input  logic       floor_2_indi,
  input  logic       floor_3_indi,
  input  logic       door_open,
  output logic [6:0] req_pulse,
  output logic [6:0] call_lamp
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] PLS_LAST = 4'(PULSE_LEN - 1);

  typedef enum logic {IDLE, PULSE} state_t;

  logic [6:0] w_sync;

`ifdef CALL_SYNC_2FF_EN
  logic [6:0] r_sync1;
  logic [6:0] r_sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_raw;
      r_sync2 <= r_sync1;
    end
  end
  assign w_sync = r_sync2;
`else
  logic [6:0] r_sync1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync1 <= '0;
    else        r_sync1 <= btn_raw;
  end
  assign w_sync = r_sync1;
`endif

  logic [7:0] r_cnt [7];
  logic [6:0] r_acc;
  logic [6:0] r_acc_d;

  // The accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) r_cnt[i] <= '0;
      r_acc   <= '0;
      r_acc_d <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (w_sync[i] != r_acc[i]) begin
          if (r_cnt[i] == CNT_LAST) begin
            r_acc[i] <= ~r_acc[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
      r_acc_d <= r_acc;
    end
  end

  logic [6:0] w_press;
  logic [6:0] w_clr;

  assign w_press = r_acc & ~r_acc_d;
  // Bit map: 0 f1 up, 1 f2 down, 2 f2 up, 3 f3 down, 4 f1 car, 5 f2 car, 6 f3 car.
  assign w_clr = {floor_3_indi, floor_2_indi, floor_1_indi, floor_3_indi,
                  floor_2_indi, floor_2_indi, floor_1_indi} & {7{door_open}};

  state_t     r_state     [7];
  state_t     w_state_nxt [7];
  logic [3:0] r_pcnt      [7];
  logic [3:0] w_pcnt_nxt  [7];
  logic [6:0] r_lamp;
  logic [6:0] w_lamp_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) begin
        r_state[i] <= IDLE;
        r_pcnt[i]  <= '0;
      end
      r_lamp <= '0;
    end else begin
      for (int i = 0; i < 7; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_pcnt[i]  <= w_pcnt_nxt[i];
      end
      r_lamp <= w_lamp_nxt;
    end
  end

  // A service clear on the same edge as a press wins: the call is already answered.
  always_comb begin
    for (int i = 0; i < 7; i++) begin
      w_state_nxt[i] = r_state[i];
      w_pcnt_nxt[i]  = r_pcnt[i];
      w_lamp_nxt[i]  = r_lamp[i] & ~w_clr[i];
      case (r_state[i])
        IDLE: begin
          if (w_press[i] && !r_lamp[i] && !w_clr[i]) begin
            w_state_nxt[i] = PULSE;
            w_pcnt_nxt[i]  = '0;
            w_lamp_nxt[i]  = 1'b1;
          end
        end
        PULSE: begin
          if (r_pcnt[i] == PLS_LAST) w_state_nxt[i] = IDLE;
          else                       w_pcnt_nxt[i]  = r_pcnt[i] + 4'd1;
        end
        default: w_state_nxt[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 7; i++) req_pulse[i] = (r_state[i] == PULSE);
  end

  assign call_lamp = r_lamp;

endmodule

// File: tb/tb_elevator_call_conditioner.sv
// Self-checking bench: table of button vectors plus hand sequences, with a pulse scoreboard.
module tb_elevator_call_conditioner;

  localparam int DB = 4;
  localparam int PL = 2;
`ifdef CALL_SYNC_2FF_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int LAT = S + DB + 1;

  logic       clk;
  logic       rst_n;
  logic [6:0] btn_raw;
  logic       floor_1_indi, floor_2_indi, floor_3_indi, door_open;
  logic [6:0] req_pulse, call_lamp;

  elevator_call_conditioner #(.DEBOUNCE_CYCLES(DB), .PULSE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .floor_1_indi(floor_1_indi), .floor_2_indi(floor_2_indi), .floor_3_indi(floor_3_indi),
    .door_open(door_open), .req_pulse(req_pulse), .call_lamp(call_lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] mask;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [6:0] btn;
    int         hold;
    logic [6:0] exp_pulse;
    logic [6:0] exp_lamp;
    logic       door;
    logic [2:0] floors;
    logic [6:0] exp_lamp_clr;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[7];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [6:0] prev = '0;
  int         hi_cnt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    logic [6:0] rises;
    exp_t       e;
    if (!rst_n) begin
      prev = '0;
      for (int i = 0; i < 7; i++) hi_cnt[i] = 0;
    end else begin
      rises = req_pulse & ~prev;
      if (rises != 7'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {25'b0, rises}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("pulse_mask", {25'b0, rises}, {25'b0, e.mask});
          chk("pulse_cycle", cyc, e.cyc);
          chk("lamp_with_pulse", {25'b0, call_lamp & rises}, {25'b0, rises});
        end
      end
      for (int i = 0; i < 7; i++) begin
        if (req_pulse[i]) hi_cnt[i]++;
        else if (prev[i]) begin
          chk("pulse_width", hi_cnt[i], PL);
          hi_cnt[i] = 0;
        end
      end
      prev = req_pulse;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic set_floors(input logic door, input logic [2:0] f);
    door_open    = door;
    floor_1_indi = f[0];
    floor_2_indi = f[1];
    floor_3_indi = f[2];
  endtask

  initial begin
    int c;
    for (int i = 0; i < 7; i++) hi_cnt[i] = 0;
    vecs[0] = '{7'b0000001, 10, 7'b0000001, 7'b0000001, 1'b1, 3'b001, 7'b0000000};
    vecs[1] = '{7'b0100000,  3, 7'b0000000, 7'b0000000, 1'b1, 3'b010, 7'b0000000};
    vecs[2] = '{7'b1000100,  8, 7'b1000100, 7'b1000100, 1'b0, 3'b010, 7'b1000100};
    vecs[3] = '{7'b1000000,  8, 7'b0000000, 7'b1000100, 1'b1, 3'b100, 7'b0000100};
    vecs[4] = '{7'b0000010,  8, 7'b0000010, 7'b0000110, 1'b1, 3'b011, 7'b0000000};
    vecs[5] = '{7'b1111111,  6, 7'b1111111, 7'b1111111, 1'b1, 3'b111, 7'b0000000};
    vecs[6] = '{7'b0010000,  4, 7'b0010000, 7'b0010000, 1'b1, 3'b001, 7'b0000000};

    rst_n   = 1'b0;
    btn_raw = '0;
    set_floors(1'b0, 3'b000);
    repeat (3) tick();
    chk("reset_pulse", {25'b0, req_pulse}, 32'h0);
    chk("reset_lamp", {25'b0, call_lamp}, 32'h0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 7; v++) begin
      c = cyc;
      btn_raw = vecs[v].btn;
      if (vecs[v].exp_pulse != 7'b0) sb.push_back('{vecs[v].exp_pulse, c + LAT});
      repeat (vecs[v].hold) tick();
      btn_raw = '0;
      repeat (25) tick();
      chk($sformatf("vec%0d_lamp", v), {25'b0, call_lamp}, {25'b0, vecs[v].exp_lamp});
      set_floors(vecs[v].door, vecs[v].floors);
      tick();
      set_floors(1'b0, 3'b000);
      chk($sformatf("vec%0d_lamp_clr", v), {25'b0, call_lamp}, {25'b0, vecs[v].exp_lamp_clr});
    end

    // Press event on bit1 lands on the same edge as a floor-2 service clear.
    c = cyc;
    btn_raw = 7'b0000010;
    repeat (LAT - 1) tick();
    set_floors(1'b1, 3'b010);
    tick();
    set_floors(1'b0, 3'b000);
    chk("clear_wins_lamp", {25'b0, call_lamp}, 32'h0);
    repeat (5) tick();
    btn_raw = '0;
    repeat (20) tick();
    chk("clear_wins_lamp_late", {25'b0, call_lamp}, 32'h0);

    // Reset one edge after the bit4 pulse rises, button held through reset.
    c = cyc;
    btn_raw = 7'b0010000;
    sb.push_back('{7'b0010000, c + LAT});
    repeat (LAT) tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_pulse", {25'b0, req_pulse}, 32'h0);
    chk("async_rst_lamp", {25'b0, call_lamp}, 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    c = cyc;
    sb.push_back('{7'b0010000, c + LAT});
    repeat (LAT + 4) tick();
    chk("held_through_reset_lamp", {25'b0, call_lamp}, 32'h10);
    btn_raw = '0;
    set_floors(1'b1, 3'b001);
    tick();
    set_floors(1'b0, 3'b000);
    chk("held_through_reset_clr", {25'b0, call_lamp}, 32'h0);

    repeat (10) tick();
    chk("scoreboard_empty", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
